// File: rtl/ex_mem_stage_if.sv
// rtl/ex_mem_stage_if.sv - EX-side and MEM-side handshake/payload bundle for ex_mem_stage
interface ex_mem_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic              in_valid;
    logic              in_ready;
    logic              MemRead;
    logic              MemWrite;
    logic              MemToReg;
    logic              RegWrite;
    logic [DATA_W-1:0] ALUResult;
    logic [DATA_W-1:0] RD2;
    logic [REG_W-1:0]  Rd;

    logic              out_valid;
    logic              out_ready;
    logic              MemRead_out;
    logic              MemWrite_out;
    logic              MemToReg_out;
    logic              RegWrite_out;
    logic [DATA_W-1:0] ALUResult_out;
    logic [DATA_W-1:0] RD2_out;
    logic [REG_W-1:0]  Rd_out;

    modport master (
        output in_valid, MemRead, MemWrite, MemToReg, RegWrite, ALUResult, RD2, Rd, out_ready,
        input  in_ready, out_valid, MemRead_out, MemWrite_out, MemToReg_out, RegWrite_out,
               ALUResult_out, RD2_out, Rd_out
    );

    modport slave (
        input  in_valid, MemRead, MemWrite, MemToReg, RegWrite, ALUResult, RD2, Rd, out_ready,
        output in_ready, out_valid, MemRead_out, MemWrite_out, MemToReg_out, RegWrite_out,
               ALUResult_out, RD2_out, Rd_out
    );
endinterface

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline stage with main+skid buffer, flush and bubble-gated controls
// Optional back-pressure counter enabled by defining EX_MEM_STALL_CNT_EN.
module ex_mem_stage #(
    parameter int DATA_W         = 32,
    parameter int REG_W          = 5,
    parameter int ZERO_REG_GUARD = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    ex_mem_stage_if.slave        bus,
    output logic [31:0]          stall_cnt
);
    typedef struct packed {
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              reg_write;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] rd2;
        logic [REG_W-1:0]  rd;
    } entry_t;

    localparam logic GUARD = (ZERO_REG_GUARD != 0);

    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t in_entry;
    logic   in_fire;
    logic   out_fire;

    // Writes to $zero are squashed at capture so the stored bit is already final.
    always_comb begin
        in_entry            = '0;
        in_entry.mem_read   = bus.MemRead;
        in_entry.mem_write  = bus.MemWrite;
        in_entry.mem_to_reg = bus.MemToReg;
        in_entry.reg_write  = bus.RegWrite & ~(GUARD & (bus.Rd == '0));
        in_entry.alu        = bus.ALUResult;
        in_entry.rd2        = bus.RD2;
        in_entry.rd         = bus.Rd;
    end

    assign in_fire  = bus.in_valid & ~skid_valid_q;
    assign out_fire = main_valid_q & bus.out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_fire) begin
            if (skid_valid_q) begin
                main_d = skid_q;
                if (in_fire) begin
                    skid_d = in_entry;
                end else begin
                    skid_valid_d = 1'b0;
                end
            end else if (in_fire) begin
                main_d = in_entry;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            if (!main_valid_q) begin
                main_d       = in_entry;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = in_entry;
                skid_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

    // in_ready depends only on state, never on out_ready.
    assign bus.in_ready      = ~skid_valid_q;
    assign bus.out_valid     = main_valid_q;
    assign bus.MemRead_out   = main_q.mem_read   & main_valid_q;
    assign bus.MemWrite_out  = main_q.mem_write  & main_valid_q;
    assign bus.MemToReg_out  = main_q.mem_to_reg & main_valid_q;
    assign bus.RegWrite_out  = main_q.reg_write  & main_valid_q;
    assign bus.ALUResult_out = main_q.alu;
    assign bus.RD2_out       = main_q.rd2;
    assign bus.Rd_out        = main_q.rd;

`ifdef EX_MEM_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (main_valid_q & ~bus.out_ready & ~flush) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - self-checking bench for ex_mem_stage: vector table plus in-order scoreboard
module tb_ex_mem_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [31:0] stall_cnt;

    always #5 clk = ~clk;

    ex_mem_stage_if #(.DATA_W(32), .REG_W(5)) bus ();

    ex_mem_stage dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .bus       (bus),
        .stall_cnt (stall_cnt)
    );

    typedef struct packed {
        logic [3:0]  ctrl;   // MemRead, MemWrite, MemToReg, RegWrite
        logic [31:0] alu;
        logic [31:0] rd2;
        logic [4:0]  rd;
    } txn_t;

    typedef struct {
        txn_t       t;
        logic [3:0] exp_ctrl;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;
    txn_t sb[$];
    txn_t cur;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic txn_t expect_of(input txn_t t);
        txn_t e;
        e = t;
        e.ctrl[0] = t.ctrl[0] & (t.rd != 5'd0);
        return e;
    endfunction

    function automatic txn_t observed();
        txn_t o;
        o.ctrl = {bus.MemRead_out, bus.MemWrite_out, bus.MemToReg_out, bus.RegWrite_out};
        o.alu  = bus.ALUResult_out;
        o.rd2  = bus.RD2_out;
        o.rd   = bus.Rd_out;
        return o;
    endfunction

    function automatic txn_t mk(input int i);
        txn_t t;
        t.ctrl = 4'(i) | 4'b0001;
        t.alu  = 32'h100 + 32'(i);
        t.rd2  = ~(32'h100 + 32'(i));
        t.rd   = 5'(i);
        return t;
    endfunction

    task automatic drive(input logic v, input txn_t t);
        cur           = t;
        bus.in_valid  = v;
        bus.MemRead   = t.ctrl[3];
        bus.MemWrite  = t.ctrl[2];
        bus.MemToReg  = t.ctrl[1];
        bus.RegWrite  = t.ctrl[0];
        bus.ALUResult = t.alu;
        bus.RD2       = t.rd2;
        bus.Rd        = t.rd;
    endtask

    // Inputs are set at the falling edge; this settles what fires on the next rising edge.
    task automatic cycle();
        txn_t e;
        if (flush) begin
            sb.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    chk("sb_underflow", 128'(1), 128'(0));
                end else begin
                    e = sb.pop_front();
                    chk("sb_order", 128'(observed()), 128'(e));
                end
            end
            if (bus.in_valid && bus.in_ready) sb.push_back(expect_of(cur));
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        flush = 1'b0;
        drive(1'b0, '0);
        bus.out_ready = 1'b0;
        @(negedge clk);
        sb.delete();
        reset = 1'b1;
    endtask

    vec_t vecs[5];

    initial begin
        int   k;
        int   sent;
        logic saw_block;
        logic will_push;

        vecs[0] = '{t: '{ctrl: 4'b0001, alu: 32'h0000_1234, rd2: 32'hDEAD_BEEF, rd: 5'd5},  exp_ctrl: 4'b0001};
        vecs[1] = '{t: '{ctrl: 4'b0001, alu: 32'h0000_0042, rd2: 32'h0000_0007, rd: 5'd0},  exp_ctrl: 4'b0000};
        vecs[2] = '{t: '{ctrl: 4'b1111, alu: 32'hFFFF_FFFF, rd2: 32'h8000_0001, rd: 5'd31}, exp_ctrl: 4'b1111};
        vecs[3] = '{t: '{ctrl: 4'b1011, alu: 32'h1357_9BDF, rd2: 32'h2468_ACE0, rd: 5'd0},  exp_ctrl: 4'b1010};
        vecs[4] = '{t: '{ctrl: 4'b0100, alu: 32'h0000_0000, rd2: 32'hCAFE_F00D, rd: 5'd17}, exp_ctrl: 4'b0100};

        do_reset();
        do_reset();
        chk("reset_out_valid", 128'(bus.out_valid), 128'(0));
        chk("reset_in_ready", 128'(bus.in_ready), 128'(1));
        chk("reset_outputs", 128'(observed()), 128'(0));
        chk("reset_stall_cnt", 128'(stall_cnt), 128'(0));

        for (int i = 0; i < 5; i++) begin
            drive(1'b1, vecs[i].t);
            bus.out_ready = 1'b1;
            cycle();
            chk("vec_out_valid", 128'(bus.out_valid), 128'(1));
            chk("vec_ctrl", 128'({bus.MemRead_out, bus.MemWrite_out, bus.MemToReg_out, bus.RegWrite_out}),
                128'(vecs[i].exp_ctrl));
            chk("vec_payload", 128'({bus.ALUResult_out, bus.RD2_out, bus.Rd_out}),
                128'({vecs[i].t.alu, vecs[i].t.rd2, vecs[i].t.rd}));
            drive(1'b0, '0);
            cycle();
            chk("vec_drain_valid", 128'(bus.out_valid), 128'(0));
            chk("vec_drain_ctrl", 128'({bus.MemWrite_out, bus.RegWrite_out}), 128'(0));
        end

        // Streaming 8 instructions with MEM stalled on cycles 2..4
        do_reset();
        k = 0; sent = 0; n_out = 0; saw_block = 1'b0;
        while (n_out < 8 && k < 60) begin
            if (sent < 8) drive(1'b1, mk(sent + 1));
            else drive(1'b0, '0);
            bus.out_ready = !(k >= 2 && k <= 4);
            if (!bus.in_ready) saw_block = 1'b1;
            will_push = bus.in_valid && bus.in_ready;
            cycle();
            if (will_push) sent++;
            k++;
        end
        chk("stream_out_count", 128'(n_out), 128'(8));
        chk("stream_sb_empty", 128'(sb.size()), 128'(0));
        chk("stream_in_ready_dropped", 128'(saw_block), 128'(1));
`ifdef EX_MEM_STALL_CNT_EN
        chk("stream_stall_cnt", 128'(stall_cnt), 128'(3));
`else
        chk("stream_stall_cnt", 128'(stall_cnt), 128'(0));
`endif

        // Flush with main+skid full and a new instruction offered
        do_reset();
        drive(1'b1, '{ctrl: 4'b0100, alu: 32'hA, rd2: 32'hAA, rd: 5'd1});
        cycle();
        drive(1'b1, '{ctrl: 4'b0100, alu: 32'hB, rd2: 32'hBB, rd: 5'd2});
        cycle();
        chk("flush_skid_full", 128'(bus.in_ready), 128'(0));
        flush = 1'b1;
        drive(1'b1, '{ctrl: 4'b0100, alu: 32'hC, rd2: 32'hCC, rd: 5'd3});
        cycle();
        flush = 1'b0;
        chk("flush_out_valid", 128'(bus.out_valid), 128'(0));
        chk("flush_in_ready", 128'(bus.in_ready), 128'(1));
        chk("flush_memwrite", 128'(bus.MemWrite_out), 128'(0));
        drive(1'b1, '{ctrl: 4'b1001, alu: 32'hD, rd2: 32'hDD, rd: 5'd4});
        bus.out_ready = 1'b1;
        cycle();
        drive(1'b0, '0);
        cycle();
        cycle();
        chk("flush_after_d_idle", 128'(bus.out_valid), 128'(0));
        chk("flush_sb_empty", 128'(sb.size()), 128'(0));

        // Reset while skid full and MEM stalled
        do_reset();
        drive(1'b1, mk(9));
        cycle();
        drive(1'b1, mk(10));
        cycle();
        chk("rst_skid_full", 128'(bus.in_ready), 128'(0));
        reset = 1'b0;
        drive(1'b1, mk(11));
        @(negedge clk);
        sb.delete();
        reset = 1'b1;
        drive(1'b0, '0);
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
        chk("rst_stall_cnt", 128'(stall_cnt), 128'(0));
        chk("rst_outputs", 128'(observed()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
